// File: rtl/mips_boot_pkg.sv
// Shared types and widths for the MIPS boot loader.
package mips_boot_pkg;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;

  typedef enum logic [2:0] {
    ST_LEN_LO = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHK    = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERROR  = 3'd6
  } boot_state_t;

endpackage

// File: rtl/mips_boot_word_asm.sv
// Little-endian word assembler: shifts in four bytes, first byte lands in bits 7:0.
// word is the value including the byte currently presented, so it can be captured on the 4th byte.
module mips_boot_word_asm
  import mips_boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  logic [1:0]        byte_cnt;
  logic [WORD_W-1:0] shreg;

  assign word      = {byte_in, shreg[WORD_W-1:8]};
  assign word_done = shift_en && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= 2'd0;
      shreg    <= '0;
    end else if (clr) begin
      byte_cnt <= 2'd0;
      shreg    <= '0;
    end else if (shift_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= word;
    end
  end

endmodule

// File: rtl/mips_boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the core until done.
// Define BOOT_CHECKSUM_EN to require a trailing mod-256 checksum byte over the data bytes.
//
// state  | meaning
// LEN_LO | waiting for word-count low byte
// LEN_HI | waiting for word-count high byte, range check
// DATA   | assembling and writing program words
// CHK    | waiting for checksum byte (BOOT_CHECKSUM_EN only)
// FLUSH  | final write cycle drains before release
// RUN    | load complete, core released
// ERROR  | load failed, core held
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_run,
  output logic              boot_err
);

  localparam logic [LEN_W:0] CAPACITY = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  boot_state_t        state;
  logic [7:0]         len_lo;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   words_left;
  logic [ADDR_W-1:0]  addr_cnt;
  logic               hs;
  logic               asm_clr;
  logic               asm_shift;
  logic               word_done;
  logic [WORD_W-1:0]  asm_word;

  assign hs        = rx_valid && rx_ready;
  assign len       = {rx_data, len_lo};
  assign asm_clr   = hs && (state == ST_LEN_HI);
  assign asm_shift = hs && (state == ST_DATA);

  mips_boot_word_asm u_word_asm (
    .clk       (clk),
    .reset     (reset),
    .clr       (asm_clr),
    .shift_en  (asm_shift),
    .byte_in   (rx_data),
    .word      (asm_word),
    .word_done (word_done)
  );

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= 8'd0;
    end else if (asm_shift) begin
      sum <= sum + rx_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_LEN_LO;
      len_lo     <= 8'd0;
      words_left <= '0;
      addr_cnt   <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_run   <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_LEN_LO: begin
          rx_ready <= 1'b1;
          if (hs) begin
            len_lo <= rx_data;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (hs) begin
            words_left <= len;
            if ({1'b0, len} > CAPACITY) begin
              state    <= ST_ERROR;
              rx_ready <= 1'b0;
              boot_err <= 1'b1;
            end else if (len != '0) begin
              state <= ST_DATA;
            end else begin
`ifdef BOOT_CHECKSUM_EN
              state <= ST_CHK;
`else
              state    <= ST_FLUSH;
              rx_ready <= 1'b0;
`endif
            end
          end
        end
        ST_DATA: begin
          // The assembler keeps accepting bytes while this write is in flight.
          if (hs && word_done) begin
            imem_we    <= 1'b1;
            imem_addr  <= addr_cnt;
            imem_wdata <= asm_word;
            addr_cnt   <= addr_cnt + ADDR_W'(1);
            words_left <= words_left - LEN_W'(1);
            if (words_left == LEN_W'(1)) begin
`ifdef BOOT_CHECKSUM_EN
              state <= ST_CHK;
`else
              state    <= ST_FLUSH;
              rx_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        ST_CHK: begin
          if (hs) begin
            rx_ready <= 1'b0;
            if (rx_data == sum) begin
              state    <= ST_RUN;
              core_run <= 1'b1;
            end else begin
              state    <= ST_ERROR;
              boot_err <= 1'b1;
            end
          end
        end
`endif
        ST_FLUSH: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          rx_ready <= 1'b0;
          core_run <= 1'b1;
        end
        ST_ERROR: begin
          rx_ready <= 1'b0;
          boot_err <= 1'b1;
        end
        default: begin
          state    <= ST_ERROR;
          rx_ready <= 1'b0;
          boot_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader; follows BOOT_CHECKSUM_EN if defined at build time.
module tb_mips_boot_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_run;
  logic              boot_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] obs_addr[$];
  logic [31:0]       obs_data[$];
  logic [31:0]       words[$];
  logic [7:0]        stream[$];

  mips_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_run   (core_run),
    .boot_err   (boot_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      obs_addr.push_back(imem_addr);
      obs_data.push_back(imem_wdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference stream: count LE, data bytes LE per word, optional sum of data bytes.
  task automatic build_stream();
    logic [15:0] n;
    logic [7:0]  chk;
    n   = 16'(words.size());
    chk = 8'd0;
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    foreach (words[i]) begin
      for (int b = 0; b < 4; b++) begin
        logic [7:0] by;
        by  = 8'((words[i] >> (8 * b)) & 32'hFF);
        chk = chk + by;
        stream.push_back(by);
      end
    end
`ifdef BOOT_CHECKSUM_EN
    stream.push_back(chk);
`endif
  endtask

  // Starts and ends at a falling edge; returns ok=0 if any byte was never accepted.
  task automatic send_stream(input int max_gap, input int count, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < count; i++) begin
      int gap;
      bit got;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      rx_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        rx_data = 8'($urandom);
        @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = stream[i];
      got = 1'b0;
      for (int t = 0; t < 64 && !got; t++) begin
        if (rx_ready === 1'b1) begin
          @(posedge clk);
          got = 1'b1;
        end
        @(negedge clk);
      end
      if (!got) ok = 1'b0;
    end
    rx_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    obs_addr.delete();
    obs_data.delete();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (2) @(negedge clk);
    vectors++;
    if (rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rx_ready: got %b expected 0", rx_ready);
    end
    vectors++;
    if ({imem_we, imem_addr, imem_wdata, core_run, boot_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: we=%b addr=%h wdata=%h run=%b err=%b expected all 0",
               imem_we, imem_addr, imem_wdata, core_run, boot_err);
    end
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    vectors++;
    if (rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b expected 1", rx_ready);
    end
  endtask

  task automatic test_basic();
    bit ok;
    apply_reset();
    words = {32'h0000_0013, 32'h0000_0037};
    build_stream();
    send_stream(0, stream.size(), ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL basic_handshake: stream stalled, expected all bytes accepted");
    end
`ifdef BOOT_CHECKSUM_EN
    vectors++;
    if (core_run !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_run_edge: core_run=%b expected 1 right after checksum edge", core_run);
    end
`else
    vectors++;
    if (imem_we !== 1'b1 || imem_addr !== ADDR_W'(1) || imem_wdata !== 32'h37) begin
      miscompares++;
      $display("FAIL basic_last_write: we=%b addr=%h data=%h expected 1/01/00000037",
               imem_we, imem_addr, imem_wdata);
    end
    vectors++;
    if (core_run !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_run_early_k1: core_run=%b expected 0", core_run);
    end
    @(negedge clk);
    vectors++;
    if (core_run !== 1'b0 || imem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_run_early_k2: core_run=%b we=%b expected 0/0", core_run, imem_we);
    end
    @(negedge clk);
    vectors++;
    if (core_run !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_run_edge: core_run=%b expected 1 two edges after last byte", core_run);
    end
`endif
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_addr.size() != 2) begin
      miscompares++;
      $display("FAIL basic_write_count: got %0d expected 2", obs_addr.size());
    end
    for (int i = 0; i < 2 && i < obs_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== ADDR_W'(i) || obs_data[i] !== words[i]) begin
        miscompares++;
        $display("FAIL basic_write%0d: addr=%h data=%h expected %h/%h",
                 i, obs_addr[i], obs_data[i], ADDR_W'(i), words[i]);
      end
    end
    vectors++;
    if (rx_ready !== 1'b0 || boot_err !== 1'b0 || core_run !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_final: ready=%b err=%b run=%b expected 0/0/1", rx_ready, boot_err, core_run);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    apply_reset();
    words.delete();
    build_stream();
    send_stream(0, stream.size(), ok);
    repeat (4) @(negedge clk);
    vectors++;
    if (!ok || obs_addr.size() != 0) begin
      miscompares++;
      $display("FAIL zero_len_writes: ok=%b writes=%0d expected ok and 0 writes", ok, obs_addr.size());
    end
    vectors++;
    if (core_run !== 1'b1 || boot_err !== 1'b0 || rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_len_state: run=%b err=%b ready=%b expected 1/0/0", core_run, boot_err, rx_ready);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    apply_reset();
    stream = {8'h01, 8'h01};
    send_stream(0, 2, ok);
    vectors++;
    if (!ok || boot_err !== 1'b1 || rx_ready !== 1'b0 || core_run !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_len: ok=%b err=%b ready=%b run=%b expected 1/1/0/0",
               ok, boot_err, rx_ready, core_run);
    end
    rx_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    vectors++;
    if (obs_addr.size() != 0 || rx_ready !== 1'b0 || boot_err !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_hold: writes=%0d ready=%b err=%b expected 0/0/1",
               obs_addr.size(), rx_ready, boot_err);
    end
  endtask

  task automatic test_full_capacity();
    bit ok;
    apply_reset();
    words.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) words.push_back($urandom);
    build_stream();
    send_stream(0, stream.size(), ok);
    repeat (4) @(negedge clk);
    vectors++;
    if (!ok || obs_addr.size() != words.size() || core_run !== 1'b1 || boot_err !== 1'b0) begin
      miscompares++;
      $display("FAIL full_cap_status: ok=%b writes=%0d run=%b err=%b expected 1/%0d/1/0",
               ok, obs_addr.size(), core_run, boot_err, words.size());
    end
    for (int i = 0; i < words.size() && i < obs_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== ADDR_W'(i) || obs_data[i] !== words[i]) begin
        miscompares++;
        $display("FAIL full_cap_write%0d: addr=%h data=%h expected %h/%h",
                 i, obs_addr[i], obs_data[i], ADDR_W'(i), words[i]);
      end
    end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_bad_checksum();
    bit ok;
    apply_reset();
    words = {32'h0000_0013, 32'h0000_0037};
    build_stream();
    stream[stream.size() - 1] = 8'h4B;
    send_stream(0, stream.size(), ok);
    vectors++;
    if (!ok || boot_err !== 1'b1 || core_run !== 1'b0 || rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_chk_edge: ok=%b err=%b run=%b ready=%b expected 1/1/0/0",
               ok, boot_err, core_run, rx_ready);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (core_run !== 1'b0 || obs_addr.size() != 2) begin
      miscompares++;
      $display("FAIL bad_chk_hold: run=%b writes=%0d expected 0/2", core_run, obs_addr.size());
    end
  endtask
`endif

  task automatic test_gaps();
    for (int trial = 0; trial < 4; trial++) begin
      bit ok;
      apply_reset();
      words.delete();
      if (trial == 0) begin
        words = {32'h0000_0013, 32'h0000_0037};
      end else begin
        int n;
        n = int'($urandom_range(1, 9));
        for (int i = 0; i < n; i++) words.push_back($urandom);
      end
      build_stream();
      send_stream(4, stream.size(), ok);
      for (int i = 0; i < 10 && core_run !== 1'b1; i++) @(negedge clk);
      vectors++;
      if (!ok || core_run !== 1'b1 || obs_addr.size() != words.size()) begin
        miscompares++;
        $display("FAIL gaps%0d_status: ok=%b run=%b writes=%0d expected 1/1/%0d",
                 trial, ok, core_run, obs_addr.size(), words.size());
      end
      for (int i = 0; i < words.size() && i < obs_addr.size(); i++) begin
        vectors++;
        if (obs_addr[i] !== ADDR_W'(i) || obs_data[i] !== words[i]) begin
          miscompares++;
          $display("FAIL gaps%0d_write%0d: addr=%h data=%h expected %h/%h",
                   trial, i, obs_addr[i], obs_data[i], ADDR_W'(i), words[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [31:0] mem [logic [ADDR_W-1:0]];
    apply_reset();
    words = {32'h0000_0013, 32'h0000_0037};
    build_stream();
    send_stream(0, 2 + 5, ok);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (!ok || obs_addr.size() != 1 || obs_data[0] !== 32'h13) begin
      miscompares++;
      $display("FAIL mid_partial: ok=%b writes=%0d expected 1 write of 00000013", ok, obs_addr.size());
    end
    vectors++;
    if (rx_ready !== 1'b0 || imem_we !== 1'b0 || core_run !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_async_clear: ready=%b we=%b run=%b expected 0/0/0", rx_ready, imem_we, core_run);
    end
    foreach (obs_addr[i]) mem[obs_addr[i]] = obs_data[i];
    repeat (2) @(negedge clk);
    reset = 1'b1;
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk);
    send_stream(1, stream.size(), ok);
    for (int i = 0; i < 10 && core_run !== 1'b1; i++) @(negedge clk);
    foreach (obs_addr[i]) mem[obs_addr[i]] = obs_data[i];
    vectors++;
    if (!ok || core_run !== 1'b1 || obs_addr.size() != 2) begin
      miscompares++;
      $display("FAIL mid_reload_status: ok=%b run=%b writes=%0d expected 1/1/2", ok, core_run, obs_addr.size());
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (!mem.exists(ADDR_W'(i)) || mem[ADDR_W'(i)] !== words[i]) begin
        miscompares++;
        $display("FAIL mid_mem%0d: got %h expected %h", i,
                 mem.exists(ADDR_W'(i)) ? mem[ADDR_W'(i)] : 32'hX, words[i]);
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_full_capacity();
`ifdef BOOT_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_gaps();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
